// File: rtl/conv_window_gen_pkg.sv
// Shared conv-datapath definitions: 3x3 window geometry, default pixel width
// and the element packing order used by the window generator and adder tree.
package conv_window_gen_pkg;

    localparam int WIN_K   = 3;
    localparam int WIN_NUM = WIN_K * WIN_K;
    localparam int PIX_W   = 8;

    // Element index of window row r (0 = oldest) and column c (0 = oldest).
    function automatic int win_idx(input int r, input int c);
        return WIN_K * r + c;
    endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// One row of pixel storage, single address port. The write is synchronous and
// the read is combinational, so the old word is visible in the cycle it is overwritten.
module line_buffer #(
    parameter  int DEPTH = 28,
    parameter  int WIDTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; the row>=2 gate upstream keeps stale words from ever being emitted.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two chained line buffers feed a 3x3 tap array,
// and each fully-interior neighbourhood is emitted as one packed bus.
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int IN_WIDTH = PIX_W,
    parameter int NUM      = WIN_NUM
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic [IN_WIDTH-1:0]     in_pixel,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [NUM*IN_WIDTH-1:0] out_win
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0]           col_cnt, cur_col;
    logic [RW-1:0]           row_cnt, cur_row;
    logic [IN_WIDTH-1:0]     lb0_rd, lb1_rd;
    logic [IN_WIDTH-1:0]     tap     [WIN_K][WIN_K];
    logic [IN_WIDTH-1:0]     tap_nxt [WIN_K][WIN_K];
    logic [NUM*IN_WIDTH-1:0] win_nxt;
    logic                    win_hit, last_hit;

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        cur_col  = in_sof ? '0 : col_cnt;
        cur_row  = in_sof ? '0 : row_cnt;
        win_hit  = in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        last_hit = win_hit && (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));

        for (int r = 0; r < WIN_K; r++) begin
            tap_nxt[r][0] = tap[r][1];
            tap_nxt[r][1] = tap[r][2];
        end
        tap_nxt[0][2] = lb1_rd;
        tap_nxt[1][2] = lb0_rd;
        tap_nxt[2][2] = in_pixel;

        win_nxt = '0;
        for (int r = 0; r < WIN_K; r++) begin
            for (int c = 0; c < WIN_K; c++) begin
                win_nxt[win_idx(r, c)*IN_WIDTH +: IN_WIDTH] = tap_nxt[r][c];
            end
        end
    end

    line_buffer #(.DEPTH(IMG_W), .WIDTH(IN_WIDTH)) u_lb0 (
        .clk   (clk),
        .we    (in_valid),
        .addr  (cur_col),
        .wdata (in_pixel),
        .rdata (lb0_rd)
    );

    // Row-1 data cascades into the second buffer, which then holds row-2.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(IN_WIDTH)) u_lb1 (
        .clk   (clk),
        .we    (in_valid),
        .addr  (cur_col),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_win   <= '0;
            tap       <= '{default: '0};
        end else begin
            out_valid <= win_hit;
            out_last  <= last_hit;
            if (win_hit) begin
                out_win <= win_nxt;
            end
            if (in_valid) begin
                tap <= tap_nxt;
                if (cur_col == CW'(IMG_W - 1)) begin
                    col_cnt <= '0;
                    row_cnt <= (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
                end else begin
                    col_cnt <= cur_col + 1'b1;
                    row_cnt <= cur_row;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen: a 4x4 instance for frame-sequencing corner
// cases and a 28x28 instance for the full-size all-white frame.
module tb_conv_window_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        v4, sof4, v28, sof28;
    logic [7:0]  pix4, pix28;
    logic        ov4, ol4, ov28, ol28;
    logic [71:0] ow4, ow28;

    int total = 0;
    int bad   = 0;
    logic [71:0] hold4 = '0;

    always #5 clk = ~clk;

    conv_window_gen #(.IMG_W(4), .IMG_H(4), .IN_WIDTH(8)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_sof(sof4), .in_pixel(pix4),
        .out_valid(ov4), .out_last(ol4), .out_win(ow4)
    );

    conv_window_gen #(.IMG_W(28), .IMG_H(28), .IN_WIDTH(8)) dut28 (
        .clk(clk), .rst(rst), .in_valid(v28), .in_sof(sof28), .in_pixel(pix28),
        .out_valid(ov28), .out_last(ol28), .out_win(ow28)
    );

    typedef struct {
        logic [7:0]  pix;
        logic        exp_valid;
        logic        exp_last;
        logic [71:0] exp_win;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int sum9(input logic [71:0] w);
        int s = 0;
        for (int k = 0; k < 9; k++) s += int'(w[k*8 +: 8]);
        return s;
    endfunction

    task automatic step4(input logic v, input logic s, input logic [7:0] p);
        v4 = v; sof4 = s; pix4 = p;
        @(posedge clk);
        #1;
    endtask

    task automatic step28(input logic v, input logic s, input logic [7:0] p);
        v28 = v; sof28 = s; pix28 = p;
        @(posedge clk);
        #1;
    endtask

    // Streams the 16-pixel table (offset by off), optionally with random idle gaps
    // during which in_sof is held high without in_valid and must be ignored.
    task automatic run_frame4(input string tag, input logic [7:0] off,
                              input logic sof_first, input int max_gap);
        logic [71:0] expw;
        int gaps;
        for (int i = 0; i < 16; i++) begin
            gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gaps; g++) begin
                step4(1'b0, 1'b1, 8'hEE);
                check($sformatf("%s gap valid px%0d", tag, i), 72'(ov4), 72'(0));
                check($sformatf("%s gap hold px%0d", tag, i), ow4, hold4);
            end
            step4(1'b1, sof_first && (i == 0), vecs[i].pix + off);
            check($sformatf("%s valid px%0d", tag, i), 72'(ov4), 72'(vecs[i].exp_valid));
            check($sformatf("%s last px%0d", tag, i), 72'(ol4), 72'(vecs[i].exp_last));
            if (vecs[i].exp_valid) begin
                expw = vecs[i].exp_win + {9{off}};
                hold4 = expw;
            end
            check($sformatf("%s win px%0d", tag, i), ow4, hold4);
            if (i == 10 && off == 8'd0 && max_gap == 0)
                check($sformatf("%s sum first", tag), 72'(sum9(ow4)), 72'(54));
        end
    endtask

    initial begin
        int wins;
        for (int i = 0; i < 16; i++) begin
            vecs[i].pix       = 8'(i + 1);
            vecs[i].exp_valid = 1'b0;
            vecs[i].exp_last  = 1'b0;
            vecs[i].exp_win   = '0;
        end
        vecs[10].exp_valid = 1'b1;
        vecs[10].exp_win   = {8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5, 8'd3, 8'd2, 8'd1};
        vecs[11].exp_valid = 1'b1;
        vecs[11].exp_win   = {8'd12, 8'd11, 8'd10, 8'd8, 8'd7, 8'd6, 8'd4, 8'd3, 8'd2};
        vecs[14].exp_valid = 1'b1;
        vecs[14].exp_win   = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};
        vecs[15].exp_valid = 1'b1;
        vecs[15].exp_last  = 1'b1;
        vecs[15].exp_win   = {8'd16, 8'd15, 8'd14, 8'd12, 8'd11, 8'd10, 8'd8, 8'd7, 8'd6};

        rst = 1'b1;
        v28 = 1'b0; sof28 = 1'b0; pix28 = '0;
        step4(1'b0, 1'b0, 8'h00);
        step4(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        check("reset valid4", 72'(ov4), 72'(0));
        check("reset last4", 72'(ol4), 72'(0));
        check("reset win4", ow4, 72'(0));
        check("reset valid28", 72'(ov28), 72'(0));
        check("reset win28", ow28, 72'(0));

        run_frame4("plain", 8'd0, 1'b1, 0);
        run_frame4("gaps", 8'd0, 1'b1, 2);
        run_frame4("b2b_a", 8'd0, 1'b0, 0);
        run_frame4("b2b_b", 8'd100, 1'b0, 0);

        // Partial frame of 6 pixels, then a new frame whose first pixel carries in_sof.
        for (int i = 0; i < 6; i++) begin
            step4(1'b1, i == 0, 8'(201 + i));
            check($sformatf("abort valid px%0d", i), 72'(ov4), 72'(0));
        end
        run_frame4("after_sof", 8'd0, 1'b1, 0);

        // Reset mid-frame after 10 pixels, then a fresh frame with no in_sof.
        for (int i = 0; i < 10; i++) begin
            step4(1'b1, 1'b0, 8'(51 + i));
            check($sformatf("pre_rst valid px%0d", i), 72'(ov4), 72'(0));
        end
        rst = 1'b1;
        step4(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        check("midrst valid", 72'(ov4), 72'(0));
        check("midrst last", 72'(ol4), 72'(0));
        check("midrst win", ow4, 72'(0));
        hold4 = '0;
        run_frame4("after_rst", 8'd0, 1'b0, 0);

        // Full-size frame, every pixel 255.
        v4 = 1'b0; sof4 = 1'b0;
        wins = 0;
        for (int i = 0; i < 784; i++) begin
            step28(1'b1, i == 0, 8'hFF);
            check($sformatf("big valid px%0d", i), 72'(ov28),
                  72'(((i / 28) >= 2) && ((i % 28) >= 2)));
            if (ov28) begin
                wins++;
                check($sformatf("big win %0d", wins), ow28, {72{1'b1}});
                check($sformatf("big last %0d", wins), 72'(ol28), 72'(wins == 676));
                if (wins == 1)
                    check("big sum", 72'(sum9(ow28)), 72'(2295));
            end else begin
                check($sformatf("big last idle px%0d", i), 72'(ol28), 72'(0));
            end
        end
        step28(1'b0, 1'b0, 8'h00);
        check("big trailing valid", 72'(ov28), 72'(0));
        check("big window count", 72'(wins), 72'(676));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
